mul_wb_stage: RTL and testbench

- Downstream stage of the combinational multiplier.
- Accepts each 2N-bit product with its destination register address and buffers it in a small FIFO.
- Writes the product back to the N-bit register-file write port as one or two beats: low half first, then an optional high half to the next register.
- Decouples the multiplier from register-file write-port stalls.

---
 rtl/mul_wb_stage_if.sv | 40 ++++
 rtl/mul_wb_stage.sv | 117 +++++++++++
 tb/tb_mul_wb_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_wb_stage_if.sv
// rtl/mul_wb_stage_if.sv - product-in / register-file write-back bundle for mul_wb_stage
// Product side : in_valid, in_ready, mul_rd[2N], in_rd_addr[RD_W], in_hi_en
// Write-back   : wb_valid, wb_ready, wb_addr[RD_W], wb_data[N], busy
// MUL_WB_OVF_EN: adds ovf (high half of the product non-zero, LO beat only)
interface mul_wb_stage_if #(
    parameter int N    = 16,
    parameter int RD_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [2*N-1:0]  mul_rd;
    logic [RD_W-1:0] in_rd_addr;
    logic            in_hi_en;
    logic            wb_valid;
    logic            wb_ready;
    logic [RD_W-1:0] wb_addr;
    logic [N-1:0]    wb_data;
    logic            busy;
`ifdef MUL_WB_OVF_EN
    logic            ovf;
`endif

    // Stage side
    modport slave (
        input  in_valid, mul_rd, in_rd_addr, in_hi_en, wb_ready,
        output in_ready, wb_valid, wb_addr, wb_data, busy
`ifdef MUL_WB_OVF_EN
        , output ovf
`endif
    );

    // Multiplier / register-file side
    modport master (
        output in_valid, mul_rd, in_rd_addr, in_hi_en, wb_ready,
        input  in_ready, wb_valid, wb_addr, wb_data, busy
`ifdef MUL_WB_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/mul_wb_stage.sv
// rtl/mul_wb_stage.sv - buffers multiplier products and writes them back as one or two N-bit beats
// Ports: clk, rst (synchronous, active-high), bus (mul_wb_stage_if.slave)
//   product in : bus.in_valid/in_ready, bus.mul_rd, bus.in_rd_addr, bus.in_hi_en
//   write-back : bus.wb_valid/wb_ready, bus.wb_addr, bus.wb_data; bus.busy
// Optional: MUL_WB_OVF_EN adds bus.ovf, set on the LO beat when the high half is non-zero.
module mul_wb_stage #(
    parameter int N     = 16,
    parameter int DEPTH = 2,
    parameter int RD_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    mul_wb_stage_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    logic [2*N-1:0]  prod_mem [DEPTH];
    logic [RD_W-1:0] addr_mem [DEPTH];
    logic            hi_mem   [DEPTH];

    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    state_t          state_q;
    logic [N-1:0]    hold_hi_data_q;
    logic            hold_hi_en_q;
    logic            wb_valid_q;
    logic [RD_W-1:0] wb_addr_q;
    logic [N-1:0]    wb_data_q;
    logic            ovf_q;

    logic full, empty, push, handoff, load;
    logic [2*N-1:0]  head_prod;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = bus.in_valid && !full && !rst;
    assign handoff   = wb_valid_q && bus.wb_ready;
    assign head_prod = prod_mem[rd_ptr_q];

    // A load pops the FIFO head into the holding register. It only ever sees
    // entries present at the start of the cycle, which gives the one-cycle
    // latency from acceptance to the first beat.
    always_comb begin
        load = 1'b0;
        unique case (state_q)
            IDLE:    load = !empty;
            LO:      load = handoff && !hold_hi_en_q && !empty;
            HI:      load = handoff && !empty;
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            prod_mem[wr_ptr_q] <= bus.mul_rd;
            addr_mem[wr_ptr_q] <= bus.in_rd_addr;
            hi_mem[wr_ptr_q]   <= bus.in_hi_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= IDLE;
            hold_hi_data_q <= '0;
            hold_hi_en_q   <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            ovf_q          <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(load);

            if (load) begin
                hold_hi_data_q <= head_prod[2*N-1:N];
                hold_hi_en_q   <= hi_mem[rd_ptr_q];
                wb_valid_q     <= 1'b1;
                wb_addr_q      <= addr_mem[rd_ptr_q];
                wb_data_q      <= head_prod[N-1:0];
                ovf_q          <= |head_prod[2*N-1:N];
                state_q        <= LO;
            end else if (handoff) begin
                if (state_q == LO && hold_hi_en_q) begin
                    // High half goes to the next register, wrapping at 2^RD_W
                    wb_addr_q <= wb_addr_q + RD_W'(1);
                    wb_data_q <= hold_hi_data_q;
                    ovf_q     <= 1'b0;
                    state_q   <= HI;
                end else begin
                    wb_valid_q <= 1'b0;
                    ovf_q      <= 1'b0;
                    state_q    <= IDLE;
                end
            end
        end
    end

    assign bus.in_ready = !full;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.busy     = (state_q != IDLE) || !empty;

`ifdef MUL_WB_OVF_EN
    assign bus.ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_mul_wb_stage.sv
// tb/tb_mul_wb_stage.sv - self-checking bench for mul_wb_stage
module tb_mul_wb_stage;
    localparam int N = 16;
    localparam int DEPTH = 2;
    localparam int RD_W = 4;

    typedef struct packed {
        logic            ovf;
        logic [RD_W-1:0] addr;
        logic [N-1:0]    data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    beat_t exp_q[$];

    mul_wb_stage_if #(.N(N), .RD_W(RD_W)) bus ();

    mul_wb_stage #(.N(N), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        bus.mul_rd = '0;
        bus.in_rd_addr = '0;
        bus.in_hi_en = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.mul_rd = 32'hFFFF_FFFF;
        bus.in_rd_addr = 4'd7;
        bus.in_hi_en = 1'b1;
        bus.wb_ready = 1'b1;
        tick();
        tick();
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.wb_addr !== 4'd0 || bus.wb_data !== 16'd0) begin bad++; $display("FAIL reset_wb_bus got=%h/%h exp=0/0", bus.wb_addr, bus.wb_data); end
`ifdef MUL_WB_OVF_EN
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
        bus.in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.in_valid = 1'b1; bus.mul_rd = 32'h0000_1234; bus.in_rd_addr = 4'd3; bus.in_hi_en = 1'b0;
        bus.wb_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_e0 got valid=%b busy=%b exp valid=0 busy=1", bus.wb_valid, bus.busy); end
        tick();
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 4'd3 || bus.wb_data !== 16'h1234) begin bad++; $display("FAIL single_beat got v=%b a=%h d=%h exp v=1 a=3 d=1234", bus.wb_valid, bus.wb_addr, bus.wb_data); end
        tick();
        total++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got valid=%b busy=%b exp 0/0", bus.wb_valid, bus.busy); end
    endtask

    task automatic test_two_beat();
        do_reset();
        bus.in_valid = 1'b1; bus.mul_rd = 32'hABCD_0001; bus.in_rd_addr = 4'd15; bus.in_hi_en = 1'b1;
        bus.wb_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 4'd15 || bus.wb_data !== 16'h0001) begin bad++; $display("FAIL two_lo got v=%b a=%h d=%h exp v=1 a=f d=0001", bus.wb_valid, bus.wb_addr, bus.wb_data); end
        tick();
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 4'd0 || bus.wb_data !== 16'hABCD) begin bad++; $display("FAIL two_hi got v=%b a=%h d=%h exp v=1 a=0 d=abcd", bus.wb_valid, bus.wb_addr, bus.wb_data); end
        tick();
        total++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL two_idle got valid=%b busy=%b exp 0/0", bus.wb_valid, bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] vals [3];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
        do_reset();
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.mul_rd = {16'h0000, vals[i]}; bus.in_rd_addr = 4'(i + 1); bus.in_hi_en = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got in_ready=%b exp=0", bus.in_ready); end
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== vals[i] || bus.wb_addr !== 4'(i + 1)) begin bad++; $display("FAIL bp_beat%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, bus.wb_valid, bus.wb_addr, bus.wb_data, 4'(i + 1), vals[i]); end
            tick();
        end
        total++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL bp_idle got valid=%b busy=%b exp 0/0", bus.wb_valid, bus.busy); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.in_valid = 1'b1; bus.mul_rd = 32'h5A5A_C3C3; bus.in_rd_addr = 4'd9; bus.in_hi_en = 1'b1;
        bus.wb_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 4'd10 || bus.wb_data !== 16'h5A5A) begin bad++; $display("FAIL stall_c%0d got v=%b a=%h d=%h exp v=1 a=a d=5a5a", i, bus.wb_valid, bus.wb_addr, bus.wb_data); end
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL stall_release got valid=%b exp=0", bus.wb_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.mul_rd = 32'h1000_0000 + 32'(i); bus.in_rd_addr = 4'(2 * i); bus.in_hi_en = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        tick();
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 4'd1 || bus.wb_data !== 16'h1000) begin bad++; $display("FAIL rmid_hi got v=%b a=%h d=%h exp v=1 a=1 d=1000", bus.wb_valid, bus.wb_addr, bus.wb_data); end
        bus.wb_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_after got v=%b busy=%b rdy=%b exp 0/0/1", bus.wb_valid, bus.busy, bus.in_ready); end
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_quiet%0d got valid=%b exp=0", i, bus.wb_valid); end
        end
    endtask

`ifdef MUL_WB_OVF_EN
    task automatic test_ovf();
        do_reset();
        bus.wb_ready = 1'b1;
        bus.in_valid = 1'b1; bus.mul_rd = 32'h0001_0000; bus.in_rd_addr = 4'd5; bus.in_hi_en = 1'b0;
        tick();
        bus.mul_rd = 32'h0000_FFFF;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.wb_valid !== 1'b1 || bus.ovf !== 1'b1 || bus.wb_data !== 16'h0000) begin bad++; $display("FAIL ovf_set got v=%b ovf=%b d=%h exp v=1 ovf=1 d=0000", bus.wb_valid, bus.ovf, bus.wb_data); end
        tick();
        total++; if (bus.wb_valid !== 1'b1 || bus.ovf !== 1'b0 || bus.wb_data !== 16'hFFFF) begin bad++; $display("FAIL ovf_clr got v=%b ovf=%b d=%h exp v=1 ovf=0 d=ffff", bus.wb_valid, bus.ovf, bus.wb_data); end
        tick();
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_idle got ovf=%b exp=0", bus.ovf); end
    endtask
`endif

    // Compares every completed beat with a queue of expected beats built from
    // accepted products; also checks that stalled beats do not change.
    task automatic test_random();
        beat_t obs, prev, e;
        logic  prev_stall;
        logic [2*N-1:0] p;
        int    drain;
        do_reset();
        prev_stall = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 3000 + 200; cyc++) begin
            obs.addr = bus.wb_addr;
            obs.data = bus.wb_data;
`ifdef MUL_WB_OVF_EN
            obs.ovf = bus.ovf;
`else
            obs.ovf = 1'b0;
`endif
            if (prev_stall) begin
                total++; if (bus.wb_valid !== 1'b1 || obs !== prev) begin bad++; $display("FAIL rnd_stable cyc=%0d got v=%b %h exp v=1 %h", cyc, bus.wb_valid, obs, prev); end
            end
            if (cyc < 3000) begin
                bus.wb_ready = ($urandom_range(0, 3) != 0);
                bus.in_valid = ($urandom_range(0, 2) != 0);
                p = $urandom;
                if ($urandom_range(0, 3) == 0) p[2*N-1:N] = '0;
                bus.mul_rd = p;
                bus.in_rd_addr = RD_W'($urandom);
                bus.in_hi_en = $urandom_range(0, 1) == 1;
            end else begin
                bus.wb_ready = 1'b1;
                bus.in_valid = 1'b0;
            end
            if (bus.wb_valid && bus.wb_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL rnd_extra cyc=%0d got beat %h exp none", cyc, obs);
                end else begin
                    e = exp_q.pop_front();
`ifndef MUL_WB_OVF_EN
                    e.ovf = 1'b0;
`endif
                    total++; if (obs !== e) begin bad++; $display("FAIL rnd_beat cyc=%0d got %h exp %h", cyc, obs, e); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{ovf: |bus.mul_rd[2*N-1:N], addr: bus.in_rd_addr, data: bus.mul_rd[N-1:0]});
                if (bus.in_hi_en)
                    exp_q.push_back('{ovf: 1'b0, addr: bus.in_rd_addr + RD_W'(1), data: bus.mul_rd[2*N-1:N]});
            end
            prev_stall = bus.wb_valid && !bus.wb_ready;
            prev = obs;
            tick();
        end
        drain = exp_q.size();
        total++; if (drain != 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rnd_drain got left=%0d busy=%b exp left=0 busy=0", drain, bus.busy); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        bus.mul_rd = '0;
        bus.in_rd_addr = '0;
        bus.in_hi_en = 1'b0;
        test_reset();
        test_single();
        test_two_beat();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef MUL_WB_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
